// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller bus: ID/EXE/MEM hazard inputs, data-memory
// handshake, and the pipeline enables/flushes/status the controller drives.
//   master : hazard controller (drives enables, flushes, pc_sel, status)
//   slave  : pipeline/datapath side (drives stage controls, dmem_ack)
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  // ID stage sources
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  // EXE stage destination
  logic             ewreg;
  logic             em2reg;
  logic [4:0]       erdrt;
  // MEM stage controls from EXE/MEM register
  logic             mbranch;
  logic             mzero;
  logic             mwmem;
  logic             mm2reg;
  logic [31:0]      mpc;
  logic             dmem_ack;
  // Pipeline register control
  logic             pc_en;
  logic             if_id_en;
  logic             id_exe_en;
  logic             exe_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_exe_flush;
  logic             exe_mem_flush;
  logic             pc_sel;
  logic [31:0]      pc_target;
  logic             dmem_req;
  // Status
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state;

  modport master (
    input  id_rs, id_rt, id_uses_rt, ewreg, em2reg, erdrt,
           mbranch, mzero, mwmem, mm2reg, mpc, dmem_ack,
    output pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
           if_id_flush, id_exe_flush, exe_mem_flush, pc_sel, pc_target,
           dmem_req, mem_err, stall_cnt, flush_cnt, state
  );

  modport slave (
    output id_rs, id_rt, id_uses_rt, ewreg, em2reg, erdrt,
           mbranch, mzero, mwmem, mm2reg, mpc, dmem_ack,
    input  pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
           if_id_flush, id_exe_flush, exe_mem_flush, pc_sel, pc_target,
           dmem_req, mem_err, stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, taken-branch flush
// and data-memory wait with timeout, plus saturating stall/flush counters.
// Ports:
//   clk  - pipeline clock
//   rst  - asynchronous active-high reset
//   bus  - pipe_hazard_ctrl_if.master (hazard inputs, enables/flushes, status)
// Enables, flushes, pc_sel and dmem_req are combinational from the current
// state and inputs so they act in the same cycle; state, wait counter,
// mem_err and event counters are registered.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.master  bus
);

  localparam int unsigned WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  // Value of the wait counter during the last permitted MWAIT cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2,
    MWAIT   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic pc_en_c, if_id_en_c, id_exe_en_c, exe_mem_en_c, mem_wb_en_c;
  logic if_id_flush_c, id_exe_flush_c, exe_mem_flush_c;
  logic pc_sel_c, dmem_req_c, br_evt_c;

  logic access_c, br_taken_c, load_use_c;

  // Hazard conditions from current inputs
  assign access_c   = bus.mwmem | bus.mm2reg;
  assign br_taken_c = bus.mbranch & bus.mzero;
  assign load_use_c = bus.em2reg & bus.ewreg & (bus.erdrt != 5'd0) &
                      ((bus.erdrt == bus.id_rs) |
                       (bus.id_uses_rt & (bus.erdrt == bus.id_rt)));

  // State, wait counter, error flag and event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state and per-cycle pipeline control
  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    mem_err_d       = mem_err_q;
    pc_en_c         = 1'b1;
    if_id_en_c      = 1'b1;
    id_exe_en_c     = 1'b1;
    exe_mem_en_c    = 1'b1;
    mem_wb_en_c     = 1'b1;
    if_id_flush_c   = 1'b0;
    id_exe_flush_c  = 1'b0;
    exe_mem_flush_c = 1'b0;
    pc_sel_c        = 1'b0;
    dmem_req_c      = 1'b0;
    br_evt_c        = 1'b0;

    unique case (state_q)
      RUN: begin
        dmem_req_c = access_c;
        if (access_c && !bus.dmem_ack) begin
          // Freeze the whole pipeline until memory answers
          {pc_en_c, if_id_en_c, id_exe_en_c, exe_mem_en_c, mem_wb_en_c} = 5'b0;
          wait_d  = '0;
          state_d = MWAIT;
        end else if (br_taken_c) begin
          pc_sel_c        = 1'b1;
          if_id_flush_c   = 1'b1;
          id_exe_flush_c  = 1'b1;
          exe_mem_flush_c = 1'b1;
          br_evt_c        = 1'b1;
          state_d         = FLUSH;
        end else if (load_use_c) begin
          // Hold PC and IF/ID, bubble into EXE
          pc_en_c        = 1'b0;
          if_id_en_c     = 1'b0;
          id_exe_flush_c = 1'b1;
          state_d        = LDSTALL;
        end
      end
      LDSTALL, FLUSH: state_d = RUN;
      MWAIT: begin
        dmem_req_c = access_c;
        if (bus.dmem_ack) begin
          // Pipeline advances on the ack cycle; a pending branch resolves here
          if (br_taken_c) begin
            pc_sel_c        = 1'b1;
            if_id_flush_c   = 1'b1;
            id_exe_flush_c  = 1'b1;
            exe_mem_flush_c = 1'b1;
            br_evt_c        = 1'b1;
            state_d         = FLUSH;
          end else begin
            state_d = RUN;
          end
        end else if (wait_q == WAIT_LAST) begin
          // Timeout: give up, release the pipeline for one cycle
          mem_err_d = 1'b1;
          state_d   = RUN;
        end else begin
          {pc_en_c, if_id_en_c, id_exe_en_c, exe_mem_en_c, mem_wb_en_c} = 5'b0;
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (((state_q == LDSTALL) || (state_q == MWAIT)) && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (br_evt_c && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Everything held inactive while reset is asserted
  assign bus.pc_en         = ~rst & pc_en_c;
  assign bus.if_id_en      = ~rst & if_id_en_c;
  assign bus.id_exe_en     = ~rst & id_exe_en_c;
  assign bus.exe_mem_en    = ~rst & exe_mem_en_c;
  assign bus.mem_wb_en     = ~rst & mem_wb_en_c;
  assign bus.if_id_flush   = ~rst & if_id_flush_c;
  assign bus.id_exe_flush  = ~rst & id_exe_flush_c;
  assign bus.exe_mem_flush = ~rst & exe_mem_flush_c;
  assign bus.pc_sel        = ~rst & pc_sel_c;
  assign bus.dmem_req      = ~rst & dmem_req_c;
  assign bus.pc_target     = bus.mpc;
  assign bus.mem_err       = mem_err_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;
  assign bus.state         = state_q;

endmodule
